// File: rtl/mul_div_unit_if.sv
// Request/response bundle of the RV32M multiply/divide unit: operand issue
// on one side, register-file write-back on the other.
interface mul_div_unit_if #(
  parameter int DWIDTH = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        funct3;
  logic [DWIDTH-1:0] rs1;
  logic [DWIDTH-1:0] rs2;
  logic [4:0]        rd_id;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] result;
  logic [4:0]        rdst_id;

  modport master (
    output in_valid, funct3, rs1, rs2, rd_id, flush, out_ready,
    input  in_ready, out_valid, result, rdst_id
  );

  modport slave (
    input  in_valid, funct3, rs1, rs2, rd_id, flush, out_ready,
    output in_ready, out_valid, result, rdst_id
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit, one operation in flight.
// Define MDU_FAST_MUL_EN for single-cycle multiplies; divides stay iterative.
module mul_div_unit #(
  parameter int DWIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  mul_div_unit_if.slave    bus
);
  localparam int CW = $clog2(DWIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [DWIDTH-1:0]   result_r;
  logic [4:0]          rdst_r;
  logic [CW-1:0]       cnt;

  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic [2*DWIDTH-1:0] prod;
  logic [DWIDTH-1:0]   mcand;
  logic                neg_q;
  logic                neg_r;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.rdst_id   = rdst_r;

  // Sign/magnitude correction of the raw unsigned product or quotient/remainder.
  function automatic logic [DWIDTH-1:0] fixup(input logic [2:0] op,
                                              input logic [2*DWIDTH-1:0] p,
                                              input logic nq,
                                              input logic nr);
    logic [2*DWIDTH-1:0] pp;
    logic [DWIDTH-1:0]   q;
    logic [DWIDTH-1:0]   r;
    q  = p[DWIDTH-1:0];
    r  = p[2*DWIDTH-1:DWIDTH];
    pp = nq ? -p : p;
    if (op[2])
      fixup = op[1] ? (nr ? -r : r) : (nq ? -q : q);
    else
      fixup = (op[1:0] == 2'b00) ? pp[DWIDTH-1:0] : pp[2*DWIDTH-1:DWIDTH];
  endfunction

  logic              is_div;
  logic              sgn_a;
  logic              sgn_b;
  logic              neg_a;
  logic              neg_b;
  logic [DWIDTH-1:0] mag_a;
  logic [DWIDTH-1:0] mag_b;
  logic              div_zero;
  logic              div_ovf;
  logic              fast_mul;
  logic [DWIDTH-1:0] special_res;
  logic [DWIDTH-1:0] fast_res;
  logic [DWIDTH-1:0] short_res;
  logic              accept;

  // MUL low half is sign-agnostic, so it shares the signed path with MULH.
  assign is_div = bus.funct3[2];
  assign sgn_a  = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign sgn_b  = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
  assign neg_a  = sgn_a & bus.rs1[DWIDTH-1];
  assign neg_b  = sgn_b & bus.rs2[DWIDTH-1];
  assign mag_a  = neg_a ? -bus.rs1 : bus.rs1;
  assign mag_b  = neg_b ? -bus.rs2 : bus.rs2;

  assign div_zero = is_div && (bus.rs2 == '0);
  assign div_ovf  = is_div && !bus.funct3[0] &&
                    (bus.rs1 == {1'b1, {(DWIDTH-1){1'b0}}}) && (bus.rs2 == '1);
  assign special_res = div_zero ? (bus.funct3[1] ? bus.rs1 : '1)
                                : (bus.funct3[1] ? '0 : bus.rs1);

`ifdef MDU_FAST_MUL_EN
  logic signed [2*DWIDTH+1:0] fa;
  logic signed [2*DWIDTH+1:0] fb;
  logic signed [2*DWIDTH+1:0] fp;
  assign fa = sgn_a ? {{(DWIDTH+2){bus.rs1[DWIDTH-1]}}, bus.rs1}
                    : {{(DWIDTH+2){1'b0}}, bus.rs1};
  assign fb = sgn_b ? {{(DWIDTH+2){bus.rs2[DWIDTH-1]}}, bus.rs2}
                    : {{(DWIDTH+2){1'b0}}, bus.rs2};
  assign fp = fa * fb;
  assign fast_mul = !is_div;
  assign fast_res = (bus.funct3[1:0] == 2'b00) ? fp[DWIDTH-1:0]
                                               : fp[2*DWIDTH-1:DWIDTH];
`else
  assign fast_mul = 1'b0;
  assign fast_res = '0;
`endif

  assign short_res = (div_zero || div_ovf) ? special_res : fast_res;
  assign accept    = (state == IDLE) && bus.in_valid && !bus.flush;

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide.
  logic [DWIDTH:0]     mul_sum;
  logic [DWIDTH:0]     div_cand;
  logic [DWIDTH:0]     div_diff;
  logic [2*DWIDTH-1:0] step_next;

  assign mul_sum  = {1'b0, prod[2*DWIDTH-1:DWIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
  assign div_cand = prod[2*DWIDTH-1:DWIDTH-1];
  assign div_diff = div_cand - {1'b0, mcand};
  assign step_next = op_q[2]
    ? (div_diff[DWIDTH] ? {div_cand[DWIDTH-1:0], prod[DWIDTH-2:0], 1'b0}
                        : {div_diff[DWIDTH-1:0], prod[DWIDTH-2:0], 1'b1})
    : {mul_sum, prod[DWIDTH-1:1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= '0;
      rdst_r      <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt        <= CW'(DWIDTH-1);
            in_ready_r <= 1'b0;
            if (div_zero || div_ovf || fast_mul) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              result_r    <= short_res;
              rdst_r      <= bus.rd_id;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state      <= IDLE;
            in_ready_r <= 1'b1;
          end else if (cnt == '0) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            result_r    <= fixup(op_q, step_next, neg_q, neg_r);
            rdst_r      <= rd_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.flush || bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  // Datapath: operands captured on accept, then iterated while BUSY.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= bus.funct3;
      rd_q  <= bus.rd_id;
      neg_q <= neg_a ^ neg_b;
      neg_r <= neg_a;
      prod  <= {{DWIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
      mcand <= is_div ? mag_b : mag_a;
    end else if (state == BUSY) begin
      prod <= step_next;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit (iterative and MDU_FAST_MUL_EN builds).
module tb_mul_div_unit;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  mul_div_unit_if #(.DWIDTH(32)) bus ();

  mul_div_unit #(.DWIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int SPC_LAT = 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    bus.funct3   = f3;
    bus.rs1      = a;
    bus.rs2      = b;
    bus.rd_id    = rd;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.rs1      = $urandom;
    bus.rs2      = $urandom;
    bus.rd_id    = 5'($urandom);
    bus.funct3   = 3'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic op_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    start_op(f3, a, b, 5'd17);
    wait_done(lat);
    chk({tag, " result"}, bus.result, exp);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    consume();
  endtask

  initial begin
    int          lat;
    logic [31:0] held_res;
    logic [4:0]  held_rd;
    logic        stable;
    logic        seen;

    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.funct3    = 3'd0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.rd_id     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", bus.result, 32'h0);
    chk("reset rdst_id", 32'(bus.rdst_id), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    start_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    wait_done(lat);
    chk("mul result", bus.result, 32'hFFFF_FFEB);
    chk("mul rdst_id", 32'(bus.rdst_id), 32'd5);
    chk("mul latency", 32'(lat), 32'(MUL_LAT));
    consume();
    chk("mul in_ready after consume", 32'(bus.in_ready), 32'd1);

    op_check("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    op_check("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    op_check("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    op_check("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    op_check("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    op_check("divu", 3'd5, 32'd100, 32'd7, 32'd14, DIV_LAT);
    op_check("remu", 3'd7, 32'd100, 32'd7, 32'd2, DIV_LAT);
    op_check("divu by zero", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_LAT);
    op_check("rem by zero", 3'd6, 32'd5, 32'd0, 32'd5, SPC_LAT);
    op_check("div overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
    op_check("rem overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, SPC_LAT);

    // Backpressure: result held while out_ready stays low.
    start_op(3'd5, 32'd1000, 32'd9, 5'd12);
    wait_done(lat);
    chk("bp result", bus.result, 32'd111);
    held_res = bus.result;
    held_rd  = bus.rdst_id;
    stable   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.result !== held_res || bus.rdst_id !== held_rd ||
          bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
        stable = 1'b0;
    end
    chk("bp stable", 32'(stable), 32'd1);
    chk("bp rdst_id", 32'(bus.rdst_id), 32'd12);
    consume();
    chk("bp out_valid dropped", 32'(bus.out_valid), 32'd0);
    chk("bp in_ready back", 32'(bus.in_ready), 32'd1);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    bus.funct3 = 3'd5; bus.rs1 = 32'd8; bus.rs2 = 32'd0;
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    chk("idle flush in_ready", 32'(bus.in_ready), 32'd1);
    chk("idle flush out_valid", 32'(bus.out_valid), 32'd0);

    // Flush at BUSY cycle 10.
    start_op(3'd5, 32'd100, 32'd7, 5'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush out_valid", 32'(bus.out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("flush no result", 32'(seen), 32'd0);

    // Asynchronous reset at BUSY cycle 20.
    start_op(3'd0, 32'd3, 32'd3, 5'd9);
    repeat (19) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("async rst result", bus.result, 32'h0);
    chk("async rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("async rst rdst_id", 32'(bus.rdst_id), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    op_check("divu after rst", 3'd5, 32'd9, 32'd3, 32'd3, DIV_LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide execute unit.
- Consumes the two register operands (rs1, rs2) produced by the register file read ports.
- Produces a result plus destination register ID that drive the register file write port (we, rdst_id, rdst).
- Valid/ready handshake on both sides, one operation in flight.

Parameters:
- DWIDTH, 32, operand/result width; count width is clog2(DWIDTH).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  unit can accept a request
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1  in  DWIDTH  operand A (dividend / multiplicand)
- rs2  in  DWIDTH  operand B (divisor / multiplier)
- rd_id  in  5  destination register ID
- flush  in  1  synchronous abort of any in-flight operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  DWIDTH  operation result
- rdst_id  out  5  rd_id captured with the operation

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; in_ready=1; out_valid=0; result=0; rdst_id=0; counter=0.
- States are IDLE, BUSY and DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Accept: in IDLE, when in_valid&&in_ready at an edge, the unit registers funct3, rd_id, operand magnitudes and sign flags.
  - Signed ops take the absolute value of signed operands.
  - MULHSU treats rs1 as signed and rs2 as unsigned.
  - The counter loads DWIDTH-1.
- Special cases go straight to DONE on the accept edge, with out_valid high in the next cycle:
  - Divide by zero: DIV/DIVU result=all ones; REM/REMU result=rs1.
  - Signed overflow (rs1=most negative, rs2=-1): DIV result=rs1; REM result=0.
- BUSY: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle, counter decrements.
  - The step taken with counter==0 is the last one; the next state is DONE.
  - Normal latency is DWIDTH BUSY cycles, so out_valid is asserted DWIDTH+1 cycles after the accept edge (33 at default).
- Final fixup on the BUSY->DONE edge:
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select the low half for MUL and the high half of the 2*DWIDTH product for MULH*.
  - result and rdst_id are registered here.
- DONE: result and rdst_id are held stable while out_valid=1 and out_ready=0. On out_valid&&out_ready the next state is IDLE.
  - No new request is accepted in the same cycle as the result is consumed.
  - in_ready returns to 1 the following cycle.
- flush: in BUSY or DONE, the next state is IDLE; out_valid=0 next cycle; the result is discarded.
  - flush in IDLE blocks acceptance that cycle; flush has priority over in_valid.
- Reset mid-operation aborts immediately, with the same values as reset.
- Inputs are sampled only on the accept edge; later changes to rs1, rs2 and rd_id are ignored.

Optional Feature:
- MDU_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU compute a single-cycle signed 2*DWIDTH product on the accept edge and go straight to DONE. Multiply latency is 1 cycle; divide is unchanged.
- Not defined: all multiplies use the iterative BUSY path with DWIDTH+1 cycle latency.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, rd_id=5 -> out_valid 33 cycles after accept; result=0xFFFFFFEB; rdst_id=5. With MDU_FAST_MUL_EN, out_valid after 1 cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same operands -> 0. Each with out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> result/rdst_id stable and in_ready=0. Then out_ready=1 -> out_valid drops next cycle and in_ready=1.
- Abort: flush asserted at BUSY cycle 10 -> IDLE next cycle and no out_valid. Separately, rst=0 at BUSY cycle 20 -> immediate out_valid=0, result=0, in_ready=1. The next DIVU 9/3 -> 3.
